// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one slave memory port among N_MASTER bus masters.
// Zero-cycle arbitration, at most one read outstanding, writes finish on acceptance.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | arbitrate; present the winner to the slave, grant on s_ready
//  ST_WAIT_R | read accepted, new requests stall until s_rvalid returns data
module bus_rr_arbiter #(
    parameter int N_MASTER = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_MASTER-1:0]    m_req,
    input  logic [N_MASTER-1:0]    m_we,
    input  logic [N_MASTER*AW-1:0] m_addr,
    input  logic [N_MASTER*DW-1:0] m_wdata,
    output logic [N_MASTER-1:0]    m_gnt,
    output logic [N_MASTER-1:0]    m_rvalid,
    output logic [DW-1:0]          m_rdata,
    output logic                   s_req,
    output logic                   s_we,
    output logic [AW-1:0]          s_addr,
    output logic [DW-1:0]          s_wdata,
    input  logic                   s_ready,
    input  logic                   s_rvalid,
    input  logic [DW-1:0]          s_rdata
);

    localparam int PW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_WAIT_R = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] winner;
    logic [PW-1:0] ptr_next;
    logic          found;
    logic          idle;
    logic          any_req;
    logic          accept;

    // Scan ptr, ptr+1, ... modulo N_MASTER; first requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_MASTER; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_MASTER) idx = idx - N_MASTER;
            if (!found && m_req[idx]) begin
                winner = PW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = winner + 1'b1;
        if (winner == PW'(N_MASTER - 1)) ptr_next = '0;
    end

    assign idle    = (state == ST_IDLE);
    assign any_req = |m_req;
    assign accept  = idle && any_req && s_ready;

    // Slave fields are forced to zero whenever no request is presented.
    always_comb begin
        s_req    = idle && any_req;
        s_we     = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        m_gnt    = '0;
        m_rvalid = '0;
        if (s_req) begin
            s_we    = m_we[winner];
            s_addr  = m_addr[int'(winner)*AW +: AW];
            s_wdata = m_wdata[int'(winner)*DW +: DW];
        end
        if (accept) m_gnt = N_MASTER'(1) << winner;
        if (state == ST_WAIT_R && s_rvalid) m_rvalid = N_MASTER'(1) << owner;
    end

    assign m_rdata = s_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
        end else if (accept) begin
            ptr   <= ptr_next;
            owner <= winner;
            state <= m_we[winner] ? ST_IDLE : ST_WAIT_R;
        end else if (state == ST_WAIT_R && s_rvalid) begin
            state <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed vector table, reset-mid-read
// sequence, and randomized traffic against a behavioural arbitration model.
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_req;
    logic [N-1:0]    m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]    m_gnt;
    logic [N-1:0]    m_rvalid;
    logic [DW-1:0]   m_rdata;
    logic            s_req;
    logic            s_we;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_ready;
    logic            s_rvalid;
    logic [DW-1:0]   s_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    bus_rr_arbiter #(.N_MASTER(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic        rdy;
        logic        rv;
        logic [3:0]  gnt;
        logic [3:0]  rvld;
        logic        sreq;
        logic        swe;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic fixed_fields();
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = 32'h100 * (i + 1);
            m_wdata[i*DW +: DW] = 32'hA0 + i;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; m_req = '0; m_we = '0; s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        m_addr = '0; m_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Behavioural model: one outstanding read, rotating priority pointer.
    bit         mdl_busy;
    int         mdl_ptr;
    int         mdl_owner;
    logic [3:0] e_gnt, e_rvalid;
    logic       e_sreq, e_swe;
    logic [31:0] e_addr, e_wdata;
    int         e_win;

    task automatic model_eval();
        e_gnt = '0; e_rvalid = '0; e_sreq = 0; e_swe = 0; e_addr = '0; e_wdata = '0; e_win = -1;
        if (!mdl_busy && m_req != 0) begin
            for (int k = 0; k < N; k++)
                if (e_win < 0 && m_req[(mdl_ptr + k) % N]) e_win = (mdl_ptr + k) % N;
            e_sreq  = 1;
            e_swe   = m_we[e_win];
            e_addr  = m_addr[e_win*AW +: AW];
            e_wdata = m_wdata[e_win*DW +: DW];
            if (s_ready) e_gnt = 4'(1 << e_win);
        end
        if (mdl_busy && s_rvalid) e_rvalid = 4'(1 << mdl_owner);
    endtask

    task automatic model_commit();
        if (e_win >= 0 && s_ready) begin
            mdl_ptr   = (e_win + 1) % N;
            mdl_owner = e_win;
            mdl_busy  = !m_we[e_win];
        end else if (mdl_busy && s_rvalid) begin
            mdl_busy = 0;
        end
    endtask

    initial begin
        tbl[0]  = '{4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 0, 0, 32'h000};
        tbl[1]  = '{4'hF, 4'hF, 1, 0, 4'h1, 4'h0, 1, 1, 32'h100};
        tbl[2]  = '{4'hF, 4'hF, 1, 0, 4'h2, 4'h0, 1, 1, 32'h200};
        tbl[3]  = '{4'hF, 4'hF, 1, 0, 4'h4, 4'h0, 1, 1, 32'h300};
        tbl[4]  = '{4'hF, 4'hF, 1, 0, 4'h8, 4'h0, 1, 1, 32'h400};
        tbl[5]  = '{4'hF, 4'hF, 1, 0, 4'h1, 4'h0, 1, 1, 32'h100};
        tbl[6]  = '{4'h4, 4'hF, 0, 0, 4'h0, 4'h0, 1, 1, 32'h300};
        tbl[7]  = '{4'h4, 4'hF, 0, 0, 4'h0, 4'h0, 1, 1, 32'h300};
        tbl[8]  = '{4'h4, 4'hF, 0, 0, 4'h0, 4'h0, 1, 1, 32'h300};
        tbl[9]  = '{4'h4, 4'hF, 1, 0, 4'h4, 4'h0, 1, 1, 32'h300};
        tbl[10] = '{4'h9, 4'hF, 1, 0, 4'h8, 4'h0, 1, 1, 32'h400};
        tbl[11] = '{4'h9, 4'hF, 1, 0, 4'h1, 4'h0, 1, 1, 32'h100};
        tbl[12] = '{4'h2, 4'h0, 1, 0, 4'h2, 4'h0, 1, 0, 32'h200};
        tbl[13] = '{4'h1, 4'h0, 1, 0, 4'h0, 4'h0, 0, 0, 32'h000};
        tbl[14] = '{4'h1, 4'h0, 1, 1, 4'h0, 4'h2, 0, 0, 32'h000};
        tbl[15] = '{4'h1, 4'h0, 1, 0, 4'h1, 4'h0, 1, 0, 32'h100};
        tbl[16] = '{4'h0, 4'h0, 1, 1, 4'h0, 4'h1, 0, 0, 32'h000};
        tbl[17] = '{4'h0, 4'h0, 1, 1, 4'h0, 4'h0, 0, 0, 32'h000};

        do_reset();
        @(negedge clk);
        chk("reset_gnt",   0, 64'(m_gnt),    64'h0);
        chk("reset_sreq",  0, 64'(s_req),    64'h0);
        chk("reset_saddr", 0, 64'(s_addr),   64'h0);
        chk("reset_rvld",  0, 64'(m_rvalid), 64'h0);
        @(posedge clk); #1;

        fixed_fields();
        s_rdata = 32'hDEADBEEF;
        for (int r = 0; r < 18; r++) begin
            m_req = tbl[r].req; m_we = tbl[r].we; s_ready = tbl[r].rdy; s_rvalid = tbl[r].rv;
            @(negedge clk);
            chk("tbl_gnt",   r, 64'(m_gnt),    64'(tbl[r].gnt));
            chk("tbl_rvld",  r, 64'(m_rvalid), 64'(tbl[r].rvld));
            chk("tbl_sreq",  r, 64'(s_req),    64'(tbl[r].sreq));
            chk("tbl_swe",   r, 64'(s_we),     64'(tbl[r].swe));
            chk("tbl_saddr", r, 64'(s_addr),   64'(tbl[r].addr));
            chk("tbl_rdata", r, 64'(m_rdata),  64'h0DEADBEEF);
            @(posedge clk); #1;
        end

        // Reset while a read is outstanding: the late response must be dropped.
        m_req = 4'h4; m_we = 4'h0; s_ready = 1'b1; s_rvalid = 1'b0;
        @(negedge clk);
        chk("mid_gnt", 0, 64'(m_gnt), 64'h4);
        @(posedge clk); #1;
        m_req = 4'h0;
        @(negedge clk);
        chk("mid_sreq_wait", 0, 64'(s_req), 64'h0);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        s_rvalid = 1'b1;
        @(negedge clk);
        chk("mid_rvld_drop", 0, 64'(m_rvalid), 64'h0);
        @(posedge clk); #1;
        s_rvalid = 1'b0; m_req = 4'hA; m_we = 4'hF;
        @(negedge clk);
        chk("mid_gnt_after", 0, 64'(m_gnt), 64'h2);
        chk("mid_sreq_after", 0, 64'(s_req), 64'h1);
        @(posedge clk); #1;

        do_reset();
        mdl_busy = 0; mdl_ptr = 0; mdl_owner = 0;
        for (int c = 0; c < 3000; c++) begin
            m_req    = 4'($urandom_range(0, 15));
            m_we     = 4'($urandom_range(0, 15));
            s_ready  = ($urandom_range(0, 3) != 0);
            s_rvalid = ($urandom_range(0, 2) == 0);
            s_rdata  = $urandom;
            for (int i = 0; i < N; i++) begin
                m_addr[i*AW +: AW]  = $urandom;
                m_wdata[i*DW +: DW] = $urandom;
            end
            model_eval();
            @(negedge clk);
            chk("rnd_gnt",   c, 64'(m_gnt),    64'(e_gnt));
            chk("rnd_rvld",  c, 64'(m_rvalid), 64'(e_rvalid));
            chk("rnd_sreq",  c, 64'(s_req),    64'(e_sreq));
            chk("rnd_swe",   c, 64'(s_we),     64'(e_swe));
            chk("rnd_saddr", c, 64'(s_addr),   64'(e_addr));
            chk("rnd_wdata", c, 64'(s_wdata),  64'(e_wdata));
            chk("rnd_rdata", c, 64'(m_rdata),  64'(s_rdata));
            @(posedge clk);
            model_commit();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter sharing one slave memory port of the SoC bus among N masters: CPU instruction fetch, CPU data, ISP UART debugger, VGA framebuffer reader. Picks one requester per transaction, muxes its address and write data onto the slave, and routes the slave's read response back to the owner. At most one read is outstanding; writes complete on slave acceptance.

## Interface
- N_MASTER, 4: number of masters (2..8)
- AW, 32: address width
- DW, 32: data width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- m_req  in  N_MASTER  per-master request, held until granted
- m_we  in  N_MASTER  per-master 1=write, 0=read
- m_addr  in  N_MASTER*AW  packed addresses, master i at [i*AW +: AW]
- m_wdata  in  N_MASTER*DW  packed write data
- m_gnt  out  N_MASTER  one-hot, request accepted this cycle
- m_rvalid  out  N_MASTER  one-hot, read data valid for that master
- m_rdata  out  DW  read data, shared by all masters
- s_req  out  1  slave request
- s_we  out  1  slave write enable
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_ready  in  1  slave accepts s_req this cycle
- s_rvalid  in  1  slave read data valid (≥1 cycle after acceptance)
- s_rdata  in  DW  slave read data

## Operation
- State register: IDLE, WAIT_R. Registered: state, ptr (round-robin pointer, $clog2(N_MASTER) bits), owner (same width).
- Winner (combinational): first i with m_req[i]=1 scanning ptr, ptr+1, ... modulo N_MASTER.
- IDLE, any m_req: s_req=1; s_we/s_addr/s_wdata = winner's fields. If s_ready=1: m_gnt[winner]=1; ptr<=winner+1 mod N_MASTER (wraps N_MASTER-1 -> 0); owner<=winner; state<=WAIT_R if read, stay IDLE if write.
- IDLE, s_ready=0: nothing registered; winner re-evaluated next cycle (requests may change, no lock).
- IDLE, no m_req: s_req=0, s_we=0, s_addr=0, s_wdata=0, m_gnt=0.
- WAIT_R: s_req=0, m_gnt=0; new requests stall. On s_rvalid=1: m_rvalid[owner]=1, state<=IDLE.
- m_rdata = s_rdata always (pass-through); qualified only by m_rvalid.
- s_rvalid in IDLE is ignored: m_rvalid stays 0.
- Only the winner is granted; losers keep m_req high and get served in round-robin order, so no master waits more than N_MASTER-1 transactions once its turn arrives.

## Timing
- Reset: state=IDLE, ptr=0, owner=0; all outputs 0 while no m_req asserted.
- Grant is combinational from m_req and s_ready: request seen and accepted in the same cycle (0-cycle arbitration).
- Write: done in the grant cycle; next arbitration in the following cycle, so back-to-back writes give one grant per cycle.
- Read: grant at cycle T, m_rvalid in the same cycle as s_rvalid (≥T+1), next grant no earlier than the cycle after s_rvalid.
- s_rvalid and a new m_req in the same WAIT_R cycle: the response is delivered; the new request waits until the next cycle (IDLE).
- Reset asserted in WAIT_R: state goes straight to IDLE, ptr=0; a later s_rvalid for the aborted read is dropped.
- ptr advances only on an accepted grant, never on s_ready=0 cycles.

## Test plan
- Single read: reset, m_req=4'b0001 read addr 0x100, s_ready=1, s_rvalid 2 cycles later with s_rdata=0xDEADBEEF -> m_gnt=0001 at T, m_rvalid=0001 at T+2, m_rdata=0xDEADBEEF, s_req=0 at T+1..T+2.
- Round-robin: all four masters hold write requests, s_ready=1 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; s_addr follows each master's address.
- Backpressure: master 2 write, s_ready=0 for 3 cycles then 1 -> s_req=1 throughout, m_gnt=0 for 3 cycles, then 0100 once; ptr becomes 3.
- Wrap and priority: ptr=3 after serving master 2; masters 0 and 3 request -> master 3 granted first, then master 0, ptr back to 1.
- Stall during read: master 1 read outstanding, master 0 requests -> master 0 gets no grant until the cycle after s_rvalid; m_rvalid only on bit 1.
- Reset mid-read: rst_n low in WAIT_R, release, then s_rvalid pulse -> m_rvalid stays 0, state IDLE, next request granted normally.
